// File: rtl/seg_pkg.sv
// Shared constants and helpers for the multiplexed 7-segment scan driver.
package seg_pkg;

  localparam int unsigned SEG_W  = 8;
  localparam int unsigned SEG_DP = 0;
  localparam int unsigned SEG_A  = 1;
  localparam int unsigned SEG_B  = 2;
  localparam int unsigned SEG_C  = 3;
  localparam int unsigned SEG_D  = 4;
  localparam int unsigned SEG_E  = 5;
  localparam int unsigned SEG_F  = 6;
  localparam int unsigned SEG_G  = 7;

  // One stored digit: segments g..a above the decimal point.
  typedef struct packed {
    logic [6:0] pattern;
    logic       dot;
  } seg_word_t;

  // Counter width that also stays legal for a modulus of 1.
  function automatic int unsigned bits_for(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic logic [31:0] onehot(input logic [31:0] idx, input int unsigned n);
    if (idx < n) return 32'd1 << idx[4:0];
    return 32'd0;
  endfunction

  function automatic logic [31:0] apply_pol(input logic [31:0] val, input logic act_low);
    return act_low ? ~val : val;
  endfunction

endpackage

// File: rtl/seg_scan_if.sv
// Write port, masks and display pins of the scan driver.
interface seg_scan_if
  import seg_pkg::*;
#(
  parameter int unsigned NUM_DIGITS = 4
) ();

  localparam int unsigned AW = bits_for(NUM_DIGITS);

  logic                  wr_en;
  logic [AW-1:0]         wr_addr;
  logic [6:0]            wr_pattern;
  logic                  wr_dot;
  logic [NUM_DIGITS-1:0] blank_mask;
  logic [NUM_DIGITS-1:0] blink_mask;
  logic [SEG_W-1:0]      seg_out;
  logic [NUM_DIGITS-1:0] an_out;
  logic [AW-1:0]         digit_idx;
  logic                  frame_tick;

  modport master (
    output wr_en, wr_addr, wr_pattern, wr_dot, blank_mask, blink_mask,
    input  seg_out, an_out, digit_idx, frame_tick
  );

  modport slave (
    input  wr_en, wr_addr, wr_pattern, wr_dot, blank_mask, blink_mask,
    output seg_out, an_out, digit_idx, frame_tick
  );

endinterface

// File: rtl/tick_divider.sv
// Modulo-MAX counter advancing when enabled; wrap_c_o flags the cycle it returns to zero.
module tick_divider
  import seg_pkg::*;
#(
  parameter  int unsigned MAX = 4,
  localparam int unsigned CW  = bits_for(MAX)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en_i,
  output logic [CW-1:0] count_o,
  output logic          wrap_c_o
);

  logic [CW-1:0] count_q, count_d;
  logic          wrap;

  always_comb begin
    count_d = count_q;
    wrap    = en_i && (count_q == CW'(MAX - 1));
    if (en_i) count_d = wrap ? '0 : count_q + CW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end

  assign count_o  = count_q;
  assign wrap_c_o = wrap;

endmodule

// File: rtl/seg_scan_driver.sv
// Self-scanning N-digit 7-segment driver with anti-ghost guard, blanking and blink.
// Outputs are computed from next-cycle scan state so they line up with digit_idx.
module seg_scan_driver
  import seg_pkg::*;
#(
  parameter int unsigned NUM_DIGITS   = 4,
  parameter int unsigned REFRESH_DIV  = 50000,
  parameter int unsigned GUARD_CYCLES = 2,
  parameter int unsigned BLINK_FRAMES = 64,
  parameter bit          SEG_ACT_LOW  = 1'b1,
  parameter bit          AN_ACT_LOW   = 1'b1
) (
  input logic       clk,
  input logic       rst,
  seg_scan_if.slave bus
);

  localparam int unsigned AW = bits_for(NUM_DIGITS);
  localparam int unsigned PW = bits_for(REFRESH_DIV);
  localparam int unsigned FW = bits_for(BLINK_FRAMES);

  localparam logic [SEG_W-1:0]      SEG_IDLE = SEG_W'(apply_pol(32'd0, SEG_ACT_LOW));
  localparam logic [NUM_DIGITS-1:0] AN_IDLE  = NUM_DIGITS'(apply_pol(32'd0, AN_ACT_LOW));

  logic [PW-1:0]         pre_cnt, pre_nxt;
  logic                  pre_wrap;
  logic [FW-1:0]         frame_cnt_unused;
  logic                  blink_wrap, frame_c;
  logic [AW-1:0]         idx_q, idx_d;
  logic                  blink_on_q, blink_on_d;
  logic                  frame_tick_q;
  seg_word_t             regs_q [NUM_DIGITS];
  seg_word_t             regs_d [NUM_DIGITS];
  logic [SEG_W-1:0]      seg_q, seg_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic                  lit;

  tick_divider #(.MAX(REFRESH_DIV)) u_slot_div (
    .clk      (clk),
    .rst      (rst),
    .en_i     (1'b1),
    .count_o  (pre_cnt),
    .wrap_c_o (pre_wrap)
  );

  tick_divider #(.MAX(BLINK_FRAMES)) u_blink_div (
    .clk      (clk),
    .rst      (rst),
    .en_i     (frame_c),
    .count_o  (frame_cnt_unused),
    .wrap_c_o (blink_wrap)
  );

  // Scan sequencing and register-file writes.
  always_comb begin
    pre_nxt    = pre_wrap ? '0 : pre_cnt + PW'(1);
    idx_d      = idx_q;
    frame_c    = pre_wrap && (idx_q == AW'(NUM_DIGITS - 1));
    if (pre_wrap) idx_d = frame_c ? '0 : idx_q + AW'(1);
    blink_on_d = blink_on_q ^ blink_wrap;
    regs_d     = regs_q;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if (bus.wr_en && (bus.wr_addr == AW'(i))) begin
        regs_d[i].pattern = bus.wr_pattern;
        regs_d[i].dot     = bus.wr_dot;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q        <= '0;
      blink_on_q   <= 1'b1;
      frame_tick_q <= 1'b0;
      for (int unsigned i = 0; i < NUM_DIGITS; i++) regs_q[i] <= '0;
    end else begin
      idx_q        <= idx_d;
      blink_on_q   <= blink_on_d;
      frame_tick_q <= frame_c;
      regs_q       <= regs_d;
    end
  end

  // Anode gating and segment mux for the slot state the next cycle will hold.
  always_comb begin
    lit  = (32'(pre_nxt) >= GUARD_CYCLES)
        && !bus.blank_mask[idx_d]
        && !(bus.blink_mask[idx_d] && !blink_on_d);
    an_d  = NUM_DIGITS'(apply_pol(lit ? onehot(32'(idx_d), NUM_DIGITS) : 32'd0, AN_ACT_LOW));
    seg_d = SEG_W'(apply_pol(lit ? 32'(regs_q[idx_d]) : 32'd0, SEG_ACT_LOW));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg_q <= SEG_IDLE;
      an_q  <= AN_IDLE;
    end else begin
      seg_q <= seg_d;
      an_q  <= an_d;
    end
  end

  assign bus.seg_out    = seg_q;
  assign bus.an_out     = an_q;
  assign bus.digit_idx  = idx_q;
  assign bus.frame_tick = frame_tick_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed bench for seg_scan_driver: 4-digit and 3-digit builds, DIV=8, GUARD=2, BLINK=2, active-low.
module tb_seg_scan_driver;

  logic clk;
  logic rst;
  int   cyc;
  int   total;
  int   bad;

  logic [7:0] exp4 [4];
  logic [7:0] exp3 [3];

  seg_scan_if #(.NUM_DIGITS(4)) bus4 ();
  seg_scan_if #(.NUM_DIGITS(3)) bus3 ();

  seg_scan_driver #(
    .NUM_DIGITS(4), .REFRESH_DIV(8), .GUARD_CYCLES(2), .BLINK_FRAMES(2),
    .SEG_ACT_LOW(1'b1), .AN_ACT_LOW(1'b1)
  ) dut4 (.clk(clk), .rst(rst), .bus(bus4));

  seg_scan_driver #(
    .NUM_DIGITS(3), .REFRESH_DIV(8), .GUARD_CYCLES(2), .BLINK_FRAMES(2),
    .SEG_ACT_LOW(1'b1), .AN_ACT_LOW(1'b1)
  ) dut3 (.clk(clk), .rst(rst), .bus(bus3));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Clock edges since reset release; slot k = cyc%8, digit = (cyc/8)%N.
  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  task automatic wait_phase(input int period, input int target);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (((cyc % period) != target) && (n < 200));
    total++;
    if ((cyc % period) != target) begin
      bad++;
      $display("FAIL wait_phase: cyc=%0d want phase %0d of %0d", cyc, target, period);
    end
  endtask

  task automatic write4(input int a, input logic [6:0] p, input logic d);
    bus4.wr_en = 1'b1; bus4.wr_addr = 2'(a); bus4.wr_pattern = p; bus4.wr_dot = d;
    @(negedge clk);
    bus4.wr_en = 1'b0;
  endtask

  task automatic write3(input int a, input logic [6:0] p, input logic d);
    bus3.wr_en = 1'b1; bus3.wr_addr = 2'(a); bus3.wr_pattern = p; bus3.wr_dot = d;
    @(negedge clk);
    bus3.wr_en = 1'b0;
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    total += 3;
    if (bus4.seg_out !== 8'hFF) begin bad++; $display("FAIL reset_seg: got %h want ff", bus4.seg_out); end
    if (bus4.an_out !== 4'hF) begin bad++; $display("FAIL reset_an: got %h want f", bus4.an_out); end
    if (bus4.frame_tick !== 1'b0) begin bad++; $display("FAIL reset_tick: got %b want 0", bus4.frame_tick); end
    rst = 1'b0;
    total++;
    if (bus4.digit_idx !== 2'd0) begin bad++; $display("FAIL reset_idx: got %0d want 0", bus4.digit_idx); end
    wait_phase(32, 11);
    total++;
    if (bus4.an_out !== 4'hD) begin bad++; $display("FAIL pre_reset_an: got %h want d", bus4.an_out); end
    #2 rst = 1'b1;
    #1;
    total += 3;
    if (bus4.an_out !== 4'hF) begin bad++; $display("FAIL async_an: got %h want f", bus4.an_out); end
    if (bus4.seg_out !== 8'hFF) begin bad++; $display("FAIL async_seg: got %h want ff", bus4.seg_out); end
    if (bus4.digit_idx !== 2'd0) begin bad++; $display("FAIL async_idx: got %0d want 0", bus4.digit_idx); end
    @(negedge clk);
    rst = 1'b0;
    wait_phase(32, 1);
    total++;
    if (bus4.an_out !== 4'hF) begin bad++; $display("FAIL restart_guard: got %h want f", bus4.an_out); end
    wait_phase(32, 2);
    total += 2;
    if (bus4.an_out !== 4'hE) begin bad++; $display("FAIL restart_lit: got %h want e", bus4.an_out); end
    if (bus4.digit_idx !== 2'd0) begin bad++; $display("FAIL restart_idx: got %0d want 0", bus4.digit_idx); end
  endtask

  task automatic test_scan;
    int idx, k;
    logic [3:0] ean;
    logic [7:0] eseg;
    write4(0, 7'h3F, 1'b0);
    write4(1, 7'h06, 1'b1);
    write4(2, 7'h5B, 1'b0);
    write4(3, 7'h4F, 1'b1);
    wait_phase(32, 0);
    for (int s = 0; s < 32; s++) begin
      idx  = s / 8;
      k    = s % 8;
      ean  = (k < 2) ? 4'hF : (4'hF ^ (4'b0001 << idx));
      eseg = (k < 2) ? 8'hFF : exp4[idx];
      total += 4;
      if (bus4.an_out !== ean) begin bad++; $display("FAIL scan_an s=%0d: got %h want %h", s, bus4.an_out, ean); end
      if (bus4.seg_out !== eseg) begin bad++; $display("FAIL scan_seg s=%0d: got %h want %h", s, bus4.seg_out, eseg); end
      if (bus4.digit_idx !== 2'(idx)) begin bad++; $display("FAIL scan_idx s=%0d: got %0d want %0d", s, bus4.digit_idx, idx); end
      if (bus4.frame_tick !== (s == 0)) begin bad++; $display("FAIL scan_tick s=%0d: got %b want %b", s, bus4.frame_tick, s == 0); end
      @(negedge clk);
    end
  endtask

  task automatic test_midslot_write;
    wait_phase(32, 19);
    total++;
    if (bus4.seg_out !== 8'h49) begin bad++; $display("FAIL mid_before: got %h want 49", bus4.seg_out); end
    write4(2, 7'h66, 1'b1);
    total++;
    if (bus4.seg_out !== 8'h49) begin bad++; $display("FAIL mid_no_tear: got %h want 49", bus4.seg_out); end
    @(negedge clk);
    total++;
    if (bus4.seg_out !== 8'h32) begin bad++; $display("FAIL mid_new: got %h want 32", bus4.seg_out); end
    exp4[2] = 8'h32;
    wait_phase(32, 28);
    total++;
    if (bus4.seg_out !== exp4[3]) begin bad++; $display("FAIL mid_d3: got %h want %h", bus4.seg_out, exp4[3]); end
    wait_phase(32, 4);
    total++;
    if (bus4.seg_out !== exp4[0]) begin bad++; $display("FAIL mid_d0: got %h want %h", bus4.seg_out, exp4[0]); end
    wait_phase(32, 12);
    total++;
    if (bus4.seg_out !== exp4[1]) begin bad++; $display("FAIL mid_d1: got %h want %h", bus4.seg_out, exp4[1]); end
  endtask

  task automatic test_blank;
    bus4.blank_mask = 4'b0100;
    wait_phase(32, 16);
    for (int k = 0; k < 8; k++) begin
      total += 2;
      if (bus4.an_out !== 4'hF) begin bad++; $display("FAIL blank_an k=%0d: got %h want f", k, bus4.an_out); end
      if (bus4.seg_out !== 8'hFF) begin bad++; $display("FAIL blank_seg k=%0d: got %h want ff", k, bus4.seg_out); end
      @(negedge clk);
    end
    wait_phase(32, 26);
    total += 2;
    if (bus4.an_out !== 4'h7) begin bad++; $display("FAIL blank_d3_an: got %h want 7", bus4.an_out); end
    if (bus4.seg_out !== exp4[3]) begin bad++; $display("FAIL blank_d3_seg: got %h want %h", bus4.seg_out, exp4[3]); end
    wait_phase(32, 10);
    total++;
    if (bus4.an_out !== 4'hD) begin bad++; $display("FAIL blank_d1_an: got %h want d", bus4.an_out); end
    bus4.blank_mask = 4'b0000;
  endtask

  task automatic test_blink;
    int  f;
    logic on;
    bus4.blink_mask = 4'b0001;
    for (int i = 0; i < 4; i++) begin
      wait_phase(32, 4);
      f  = cyc / 32;
      on = ((f / 2) % 2) == 0;
      total += 2;
      if (bus4.an_out !== (on ? 4'hE : 4'hF)) begin bad++; $display("FAIL blink_an f=%0d: got %h want %h", f, bus4.an_out, on ? 4'hE : 4'hF); end
      if (bus4.seg_out !== (on ? exp4[0] : 8'hFF)) begin bad++; $display("FAIL blink_seg f=%0d: got %h want %h", f, bus4.seg_out, on ? exp4[0] : 8'hFF); end
      wait_phase(32, 12);
      total++;
      if (bus4.an_out !== 4'hD) begin bad++; $display("FAIL blink_d1 f=%0d: got %h want d", f, bus4.an_out); end
    end
    bus4.blink_mask = 4'b0000;
  endtask

  task automatic test_back_to_back;
    wait_phase(32, 23);
    write4(3, 7'h7F, 1'b1);
    total += 2;
    if (bus4.an_out !== 4'hF) begin bad++; $display("FAIL b2b_guard0: got %h want f", bus4.an_out); end
    if (bus4.digit_idx !== 2'd3) begin bad++; $display("FAIL b2b_idx: got %0d want 3", bus4.digit_idx); end
    @(negedge clk);
    total++;
    if (bus4.an_out !== 4'hF) begin bad++; $display("FAIL b2b_guard1: got %h want f", bus4.an_out); end
    @(negedge clk);
    total += 2;
    if (bus4.an_out !== 4'h7) begin bad++; $display("FAIL b2b_an: got %h want 7", bus4.an_out); end
    if (bus4.seg_out !== 8'h00) begin bad++; $display("FAIL b2b_seg: got %h want 00", bus4.seg_out); end
  endtask

  task automatic test_out_of_range;
    int idx, k;
    logic [2:0] ean;
    logic [7:0] eseg;
    write3(0, 7'h06, 1'b0);
    write3(1, 7'h5B, 1'b1);
    write3(2, 7'h4F, 1'b0);
    write3(3, 7'h7F, 1'b1);
    wait_phase(24, 0);
    for (int s = 0; s < 24; s++) begin
      idx  = s / 8;
      k    = s % 8;
      ean  = (k < 2) ? 3'h7 : (3'h7 ^ (3'b001 << idx));
      eseg = (k < 2) ? 8'hFF : exp3[idx];
      total += 3;
      if (bus3.an_out !== ean) begin bad++; $display("FAIL oob_an s=%0d: got %h want %h", s, bus3.an_out, ean); end
      if (bus3.seg_out !== eseg) begin bad++; $display("FAIL oob_seg s=%0d: got %h want %h", s, bus3.seg_out, eseg); end
      if (bus3.digit_idx !== 2'(idx)) begin bad++; $display("FAIL oob_idx s=%0d: got %0d want %0d", s, bus3.digit_idx, idx); end
      @(negedge clk);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    exp4[0] = 8'h81; exp4[1] = 8'hF2; exp4[2] = 8'h49; exp4[3] = 8'h60;
    exp3[0] = 8'hF3; exp3[1] = 8'h48; exp3[2] = 8'h61;
    bus4.wr_en = 1'b0; bus4.wr_addr = '0; bus4.wr_pattern = '0; bus4.wr_dot = 1'b0;
    bus4.blank_mask = '0; bus4.blink_mask = '0;
    bus3.wr_en = 1'b0; bus3.wr_addr = '0; bus3.wr_pattern = '0; bus3.wr_dot = 1'b0;
    bus3.blank_mask = '0; bus3.blink_mask = '0;
    test_reset();
    test_scan();
    test_midslot_write();
    test_blank();
    test_blink();
    test_back_to_back();
    test_out_of_range();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
